// File: rtl/msgq_pkg.sv
// msgq_pkg: shared definitions for the session message request queue.
//   - Message type codes carried in each queued request.
//   - Launch FSM state encoding.
//   - Drop counter width and its saturating increment helper.
package msgq_pkg;

  localparam logic [3:0] MSG_NONE   = 4'd0;
  localparam logic [3:0] LOGON      = 4'd1;
  localparam logic [3:0] HEARTBEAT  = 4'd2;
  localparam logic [3:0] RESEND_REQ = 4'd3;
  localparam logic [3:0] LOGOUT     = 4'd4;

  localparam int DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } msgq_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    logic [DROP_CNT_W-1:0] r;
    if (v == {DROP_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + DROP_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/msgq_fifo.sv
// msgq_fifo: in-order storage for message requests.
//   clk, rst       clock, asynchronous active-low reset
//   push, pop      write / read strobes (push while full only lands with a pop)
//   wr_data        {type, host} entry to store
//   rd_data        head entry, rd_idx its slot index
//   count/full/empty  registered occupancy status
//   valid          per-slot occupied flags
//   entries_flat   all slot contents side by side, slot g at [g*W +: W]
module msgq_fifo
  import msgq_pkg::*;
#(
  parameter int NUM_HOST = 10,
  parameter int DEPTH    = 8,
  localparam int W       = 4 + NUM_HOST,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         wr_data,
  output logic [W-1:0]         rd_data,
  output logic [AW-1:0]        rd_idx,
  output logic [AW:0]          count,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH-1:0]     valid,
  output logic [DEPTH*W-1:0]   entries_flat
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r, rd_ptr_r, count_r;
  logic [AW:0]   wr_ptr_nxt_s, rd_ptr_nxt_s, count_nxt_s;
  logic          full_r, empty_r;
  logic          push_s, pop_s;

  assign push_s = push & (~full_r | pop);
  assign pop_s  = pop & ~empty_r;

  // Next pointer values; the extra top bit tells full from empty.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + (AW+1)'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + (AW+1)'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
  end

  // Entry storage, written at the tail slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointers and registered occupancy status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == (AW+1)'(DEPTH));
      empty_r  <= (count_nxt_s == (AW+1)'(0));
    end
  end

  assign rd_idx  = rd_ptr_r[AW-1:0];
  assign rd_data = mem_r[rd_idx];
  assign count   = count_r;
  assign full    = full_r;
  assign empty   = empty_r;

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_view
    logic [AW-1:0] offs_s;
    assign offs_s                 = AW'(g) - rd_ptr_r[AW-1:0];
    assign valid[g]               = ({1'b0, offs_s} < count_r);
    assign entries_flat[g*W +: W] = mem_r[g];
  end

endmodule

// File: rtl/msg_request_queue.sv
// msg_request_queue: holds session message requests in order and launches
// them one at a time to the message creator with a start/busy handshake.
//   clk, rst            clock, asynchronous active-low reset
//   initiate_msg_i      push strobe; create_message_i type (0 = ignored), host_i host
//   busy_i              creator busy; clear_overflow_i clears overflow_o
//   start_o             one-cycle launch pulse; msg_type_o/host_o launched request
//   count_o/full_o/empty_o  queue status
//   overflow_o          sticky drop flag; drop_cnt_o saturating drop count
// Build option MSGQ_HB_COALESCE_EN: a heartbeat for a host that already has a
// heartbeat waiting in the queue is discarded silently.
module msg_request_queue
  import msgq_pkg::*;
#(
  parameter int NUM_HOST = 10,
  parameter int DEPTH    = 8,
  parameter int ACK_WAIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        initiate_msg_i,
  input  logic [3:0]                  create_message_i,
  input  logic [NUM_HOST-1:0]         host_i,
  input  logic                        busy_i,
  input  logic                        clear_overflow_i,
  output logic                        start_o,
  output logic [3:0]                  msg_type_o,
  output logic [NUM_HOST-1:0]         host_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        overflow_o,
  output logic [DROP_CNT_W-1:0]       drop_cnt_o
);

  localparam int W  = 4 + NUM_HOST;
  localparam int AW = $clog2(DEPTH);

  msgq_state_t               state_r, state_nxt_s;
  logic [3:0]                ack_cnt_r;
  logic                      start_r, launch_s;
  logic [3:0]                msg_type_r;
  logic [NUM_HOST-1:0]       host_r;
  logic                      overflow_r;
  logic [DROP_CNT_W-1:0]     drop_cnt_r;

  logic                      req_valid_s, coalesce_hit_s, push_s, pop_s, drop_s;
  logic [W-1:0]              fifo_head_s;
  logic [AW-1:0]             fifo_rd_idx_s;
  logic [AW:0]               fifo_count_s;
  logic                      fifo_full_s, fifo_empty_s;
  logic [DEPTH-1:0]          fifo_valid_s;
  logic [DEPTH*W-1:0]        fifo_entries_s;

  // The head leaves the queue at the end of the launch cycle.
  assign pop_s       = (state_r == ISSUE);
  assign req_valid_s = initiate_msg_i & (create_message_i != MSG_NONE);
  // A full queue still accepts a push in the cycle it pops.
  assign push_s      = req_valid_s & ~coalesce_hit_s & (~fifo_full_s | pop_s);
  assign drop_s      = req_valid_s & ~coalesce_hit_s & fifo_full_s & ~pop_s;

  msgq_fifo #(
    .NUM_HOST (NUM_HOST),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push_s),
    .pop          (pop_s),
    .wr_data      ({create_message_i, host_i}),
    .rd_data      (fifo_head_s),
    .rd_idx       (fifo_rd_idx_s),
    .count        (fifo_count_s),
    .full         (fifo_full_s),
    .empty        (fifo_empty_s),
    .valid        (fifo_valid_s),
    .entries_flat (fifo_entries_s)
  );

`ifdef MSGQ_HB_COALESCE_EN
  // Parallel search for a waiting heartbeat to the same host; the head being
  // launched this cycle is already issued and does not count.
  always_comb begin
    coalesce_hit_s = 1'b0;
    if (create_message_i == HEARTBEAT) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_valid_s[i]
            && (fifo_entries_s[i*W+NUM_HOST +: 4] == HEARTBEAT)
            && (fifo_entries_s[i*W +: NUM_HOST] == host_i)
            && !(pop_s && (AW'(i) == fifo_rd_idx_s))) begin
          coalesce_hit_s = 1'b1;
        end else begin
          coalesce_hit_s = coalesce_hit_s;
        end
      end
    end else begin
      coalesce_hit_s = 1'b0;
    end
  end
`else
  assign coalesce_hit_s = 1'b0;
  logic unused_fifo_view_s;
  assign unused_fifo_view_s = ^{fifo_valid_s, fifo_entries_s, fifo_rd_idx_s};
`endif

  // Launch FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    launch_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s && !busy_i) begin
          state_nxt_s = ISSUE;
          launch_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (busy_i) begin
          state_nxt_s = WAIT_DONE;
        end else if (ack_cnt_r == 4'(ACK_WAIT - 1)) begin
          // No acknowledge: the request is considered consumed.
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_ACK;
        end
      end
      WAIT_DONE: begin
        if (!busy_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register and acknowledge-wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      ack_cnt_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == WAIT_ACK) begin
        ack_cnt_r <= ack_cnt_r + 4'd1;
      end else begin
        ack_cnt_r <= 4'd0;
      end
    end
  end

  // Launch pulse and launched request fields, held until the next launch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_r    <= 1'b0;
      msg_type_r <= 4'd0;
      host_r     <= '0;
    end else begin
      start_r <= (state_nxt_s == ISSUE);
      if (launch_s) begin
        msg_type_r <= fifo_head_s[W-1 -: 4];
        host_r     <= fifo_head_s[NUM_HOST-1:0];
      end
    end
  end

  // Overflow flag (clear wins over a same-cycle drop) and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      if (clear_overflow_i) begin
        overflow_r <= 1'b0;
      end else if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (drop_s) begin
        drop_cnt_r <= sat_inc(drop_cnt_r);
      end
    end
  end

  assign start_o    = start_r;
  assign msg_type_o = msg_type_r;
  assign host_o     = host_r;
  assign count_o    = fifo_count_s;
  assign full_o     = fifo_full_s;
  assign empty_o    = fifo_empty_s;
  assign overflow_o = overflow_r;
  assign drop_cnt_o = drop_cnt_r;

endmodule

// File: tb/tb_msg_request_queue.sv
// Bench for msg_request_queue: a request-level model (a plain queue plus the
// launch timing rules) predicts status every cycle and pushes expected launches
// into a scoreboard; a monitor pops and compares on every start_o pulse.
module tb_msg_request_queue;

  localparam int NH       = 10;
  localparam int DEPTH    = 8;
  localparam int ACK_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          initiate_msg_i = 1'b0;
  logic [3:0]    create_message_i = 4'd0;
  logic [NH-1:0] host_i = '0;
  logic          busy_i = 1'b0;
  logic          clear_overflow_i = 1'b0;
  logic          start_o;
  logic [3:0]    msg_type_o;
  logic [NH-1:0] host_o;
  logic [3:0]    count_o;
  logic          full_o, empty_o, overflow_o;
  logic [7:0]    drop_cnt_o;

  always #5 clk = ~clk;

  msg_request_queue #(.NUM_HOST(NH), .DEPTH(DEPTH), .ACK_WAIT(ACK_WAIT)) dut (
    .clk(clk), .rst(rst), .initiate_msg_i(initiate_msg_i),
    .create_message_i(create_message_i), .host_i(host_i), .busy_i(busy_i),
    .clear_overflow_i(clear_overflow_i), .start_o(start_o), .msg_type_o(msg_type_o),
    .host_o(host_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  typedef struct { logic [3:0] ty; logic [NH-1:0] ho; } req_t;
  typedef struct { logic [3:0] ty; logic [NH-1:0] ho; int cyc; } launch_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state
  req_t          mq[$];
  launch_t       exp_q[$];
  bit            m_over = 1'b0;
  int            m_drop = 0;
  bit            m_issue = 1'b0;
  int            free_at = 0;
  int            b0 = 1, b1 = 0;
  bit            force_busy = 1'b0;
  int            resp_mode = 0;
  logic [3:0]    m_type = 4'd0;
  logic [NH-1:0] m_host = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic bit busy_now(input int k);
    return force_busy || (k >= b0 && k <= b1);
  endfunction

  // Effect of one clock edge on the model, given the inputs held in cycle k.
  task automatic model_edge(input int k, input bit p, input logic [3:0] p_ty,
                            input logic [NH-1:0] p_ho, input bit clr, input bit bz);
    bit pop, launch, coal, was_full, drop;
    int sz, d, len, s;
    pop    = m_issue;
    sz     = mq.size();
    launch = !m_issue && (k >= free_at) && (sz > 0) && !bz;
    if (launch) begin
      s = k + 1;
      exp_q.push_back('{ty: mq[0].ty, ho: mq[0].ho, cyc: s});
      m_type = mq[0].ty;
      m_host = mq[0].ho;
      case (resp_mode)
        1: begin d = ACK_WAIT; len = 1; end
        2: begin d = 0; len = 1; end
        3: begin d = 0; len = 30; end
        default: begin d = $urandom_range(0, ACK_WAIT); len = $urandom_range(1, 4); end
      endcase
      if (d < ACK_WAIT) begin
        b0 = s + 1 + d; b1 = s + d + len; free_at = s + 2 + d + len;
      end else begin
        b0 = 1; b1 = 0; free_at = s + ACK_WAIT + 1;
      end
    end
    coal = 1'b0;
`ifdef MSGQ_HB_COALESCE_EN
    if (p && p_ty == 4'd2) begin
      for (int i = (pop ? 1 : 0); i < sz; i++) begin
        if (mq[i].ty == 4'd2 && mq[i].ho == p_ho) coal = 1'b1;
      end
    end
`endif
    was_full = (sz == DEPTH);
    if (pop) void'(mq.pop_front());
    drop = 1'b0;
    if (p && p_ty != 4'd0 && !coal) begin
      if (!was_full || pop) mq.push_back('{ty: p_ty, ho: p_ho});
      else drop = 1'b1;
    end
    if (clr) m_over = 1'b0;
    else if (drop) m_over = 1'b1;
    if (drop && m_drop < 255) m_drop++;
    m_issue = launch;
  endtask

  task automatic check_status();
    chk("count_o", 32'(count_o), 32'(mq.size()));
    chk("full_o", 32'(full_o), 32'(mq.size() == DEPTH));
    chk("empty_o", 32'(empty_o), 32'(mq.size() == 0));
    chk("overflow_o", 32'(overflow_o), 32'(m_over));
    chk("drop_cnt_o", 32'(drop_cnt_o), 32'(m_drop));
    chk("msg_type_o", 32'(msg_type_o), 32'(m_type));
    chk("host_o", 32'(host_o), 32'(m_host));
  endtask

  // Drive one cycle of inputs, advance the model, check at the next falling edge.
  task automatic step(input bit p, input logic [3:0] p_ty, input logic [NH-1:0] p_ho, input bit clr);
    int k;
    bit bz;
    k = cyc;
    bz = busy_now(k);
    initiate_msg_i   = p;
    create_message_i = p_ty;
    host_i           = p_ho;
    clear_overflow_i = clr;
    busy_i           = bz;
    model_edge(k, p, p_ty, p_ho, clr, bz);
    @(negedge clk);
    check_status();
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (mq.size() == 0 && !m_issue && cyc >= free_at) break;
      step(1'b0, 4'd0, '0, 1'b0);
    end
    chk("drained_count", 32'(count_o), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_start"}, 32'(start_o), 32'd0);
    chk({tag, "_type"}, 32'(msg_type_o), 32'd0);
    chk({tag, "_host"}, 32'(host_o), 32'd0);
    chk({tag, "_count"}, 32'(count_o), 32'd0);
    chk({tag, "_empty"}, 32'(empty_o), 32'd1);
    chk({tag, "_full"}, 32'(full_o), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow_o), 32'd0);
    chk({tag, "_drop"}, 32'(drop_cnt_o), 32'd0);
  endtask

  // Scoreboard monitor: every launch pulse must match the oldest expected launch.
  always @(negedge clk) begin
    if (rst) begin
      if (start_o) begin
        chk("launch_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          launch_t e;
          e = exp_q.pop_front();
          chk("launch_type", 32'(msg_type_o), 32'(e.ty));
          chk("launch_host", 32'(host_o), 32'(e.ho));
          chk("launch_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        void'(exp_q.pop_front());
        chk("launch_missing", 32'(start_o), 32'd1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    // Reset values
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    @(negedge clk);
    check_status();

    // Single logon for host 5 with no responder
    resp_mode = 1;
    k0 = cyc;
    step(1'b1, 4'd1, NH'(5), 1'b0);
    step(1'b0, 4'd0, '0, 1'b0);
    chk("t1_cycle_offset", 32'(cyc - k0), 32'd2);
    chk("t1_start", 32'(start_o), 32'd1);
    chk("t1_type", 32'(msg_type_o), 32'd1);
    chk("t1_host", 32'(host_o), 32'd5);
    for (int i = 0; i < 6; i++) step(1'b0, 4'd0, '0, 1'b0);
    chk("t1_count_after", 32'(count_o), 32'd0);
    chk("t1_no_restart", 32'(start_o), 32'd0);

    // Type 0 push is ignored
    step(1'b1, 4'd0, NH'(7), 1'b0);
    chk("ignored_count", 32'(count_o), 32'd0);

    // Fill while busy, overflow, and clear colliding with a new overflow
    force_busy = 1'b1;
    for (int i = 0; i < 9; i++) step(1'b1, 4'($urandom_range(1, 4)), NH'(i + 10), 1'b0);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_overflow", 32'(overflow_o), 32'd1);
    chk("fill_drop", 32'(drop_cnt_o), 32'd1);
    step(1'b1, 4'd3, NH'(99), 1'b1);
    chk("clear_collide_overflow", 32'(overflow_o), 32'd0);
    chk("clear_collide_drop", 32'(drop_cnt_o), 32'd2);

    // Release busy; push in the launch cycle while full
    force_busy = 1'b0;
    resp_mode = 2;
    for (int i = 0; i < 20; i++) begin
      if (m_issue) break;
      step(1'b0, 4'd0, '0, 1'b0);
    end
    chk("issue_reached", 32'(start_o), 32'd1);
    step(1'b1, 4'd4, NH'(77), 1'b0);
    chk("push_pop_full_count", 32'(count_o), 32'd8);
    chk("push_pop_full_overflow", 32'(overflow_o), 32'd0);
    drain();

    // Reset while waiting for the creator to finish, 3 entries queued
    resp_mode = 3;
    for (int i = 0; i < 4; i++) step(1'b1, 4'd1, NH'(i + 1), 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (cyc >= b0 + 1 && cyc <= b1 && mq.size() == 3) break;
      step(1'b0, 4'd0, '0, 1'b0);
    end
    chk("pre_reset_count", 32'(count_o), 32'd3);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_reset_values("midreset");
    mq.delete();
    m_over = 1'b0; m_drop = 0; m_issue = 1'b0; free_at = 0;
    b0 = 1; b1 = 0; m_type = 4'd0; m_host = '0;
    initiate_msg_i = 1'b0; busy_i = 1'b0; clear_overflow_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_status();

    // Heartbeat coalescing
    force_busy = 1'b1;
    step(1'b1, 4'd2, NH'(3), 1'b0);
    step(1'b1, 4'd2, NH'(3), 1'b0);
    step(1'b1, 4'd2, NH'(4), 1'b0);
`ifdef MSGQ_HB_COALESCE_EN
    chk("hb_count", 32'(count_o), 32'd2);
`else
    chk("hb_count", 32'(count_o), 32'd3);
`endif
    chk("hb_drop", 32'(drop_cnt_o), 32'd0);
    force_busy = 1'b0;
    resp_mode = 0;
    drain();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 40, 4'($urandom_range(0, 4)),
           NH'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
    end
    drain();
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, '0, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
